// File: rtl/irq_pending_ctrl.sv
// ---------------------------------------------------------------------------
// irq_pending_ctrl
// Interrupt request front end for the 8-to-3 priority encoder. Synchronizes
// eight asynchronous request lines, turns rising edges (or levels) into
// pending bits, applies a software mask, and offers the highest-priority
// masked pending index to a consumer over a valid/ready handshake. The
// accepted bit is cleared from the pending register.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   irq[7:0]     asynchronous request lines, bit 7 highest priority
//   mask[7:0]    synchronous enable per line (pending still sets when masked)
//   pend_masked  registered (next pend) & mask, encoder input
//   out_valid    an index is being offered
//   out_idx      offered index, stable while out_valid=1
//   out_ready    consumer accepts on out_valid & out_ready at a rising edge
//   pend_raw     unmasked pending register
// ---------------------------------------------------------------------------
module irq_pending_ctrl #(
   parameter int SYNC_STAGES = 2,   // 2..4
   parameter bit EDGE_MODE   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] irq,
   input  logic [7:0] mask,
   output logic [7:0] pend_masked,
   output logic       out_valid,
   output logic [2:0] out_idx,
   input  logic       out_ready,
   output logic [7:0] pend_raw
);

   typedef enum logic [1:0] {S_IDLE, S_OFFER, S_GAP} state_t;

   logic [SYNC_STAGES-1:0][7:0] r_sync;
   logic [7:0] r_sync_d;
   logic [7:0] r_pend;
   logic [7:0] r_pend_masked;
   logic [2:0] r_idx;
   state_t     r_state;

   logic [7:0] w_sync;
   logic [7:0] w_set;
   logic [7:0] w_clr;
   logic [7:0] w_pend_nxt;
   logic [2:0] w_top;
   logic       w_accept;
   logic       w_load;
   state_t     w_state_nxt;

   // Synchronizer chain; stage 0 is the only flop that sees raw irq.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync   <= '0;
         r_sync_d <= '0;
      end else begin
         r_sync[0] <= irq;
         for (int s = 1; s < SYNC_STAGES; s++)
            r_sync[s] <= r_sync[s-1];
         r_sync_d <= w_sync;
      end
   end

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign w_set  = EDGE_MODE ? (w_sync & ~r_sync_d) : w_sync;

   assign w_accept   = (r_state == S_OFFER) && out_ready;
   assign w_clr      = w_accept ? (8'd1 << r_idx) : 8'd0;
   // Set is OR-ed in after the clear so a same-cycle set survives the accept.
   assign w_pend_nxt = (r_pend & ~w_clr) | w_set;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend        <= '0;
         r_pend_masked <= '0;
      end else begin
         r_pend        <= w_pend_nxt;
         r_pend_masked <= w_pend_nxt & mask;
      end
   end

   // Highest set bit of the registered masked vector; scanning upward lets
   // the highest index overwrite lower ones.
   always_comb begin
      w_top = 3'd0;
      for (int i = 0; i < 8; i++)
         if (r_pend_masked[i]) w_top = 3'(i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) r_idx <= w_top;
      end
   end

   // The offer is taken from the registered masked vector, so a mask change
   // becomes visible to the FSM one edge after it reaches pend_masked.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_pend_masked != 8'd0) begin
               w_load      = 1'b1;
               w_state_nxt = S_OFFER;
            end
         end
         S_OFFER: begin
            if (out_ready) w_state_nxt = S_GAP;
         end
         S_GAP:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign out_valid   = (r_state == S_OFFER);
   assign out_idx     = r_idx;
   assign pend_raw    = r_pend;
   assign pend_masked = r_pend_masked;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
module tb_irq_pending_ctrl;

   typedef struct {int idx; int cyc;} exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_e, mask_e, pm_e, pr_e;
   logic [7:0] irq_l, mask_l, pm_l, pr_l;
   logic       v_e, rdy_e, v_l, rdy_l;
   logic [2:0] idx_e, idx_l;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t q_e[$];
   exp_t q_l[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   irq_pending_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) dut_e (
      .clk(clk), .rst(rst), .irq(irq_e), .mask(mask_e), .pend_masked(pm_e),
      .out_valid(v_e), .out_idx(idx_e), .out_ready(rdy_e), .pend_raw(pr_e));

   irq_pending_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(1'b0)) dut_l (
      .clk(clk), .rst(rst), .irq(irq_l), .mask(mask_l), .pend_masked(pm_l),
      .out_valid(v_l), .out_idx(idx_l), .out_ready(rdy_l), .pend_raw(pr_l));

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic exp_e(input int idx, input int cy);
      exp_t e;
      e.idx = idx; e.cyc = cy;
      q_e.push_back(e);
   endtask

   task automatic exp_l(input int idx, input int cy);
      exp_t e;
      e.idx = idx; e.cyc = cy;
      q_l.push_back(e);
   endtask

   // Called only at a falling edge; cyc keeps advancing so this terminates.
   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Monitors: each new offer must match the head of the scoreboard queue
   // (index and cycle); an ongoing offer must keep its index.
   initial begin : mon_e
      logic       pv;
      logic [2:0] pidx;
      exp_t       e;
      pv = 1'b0; pidx = 3'd0;
      forever begin
         @(posedge clk); #1;
         if (v_e && !pv) begin
            chk("offer_expected_e", int'(q_e.size() != 0), 1);
            if (q_e.size() != 0) begin
               e = q_e.pop_front();
               chk("offer_idx_e", int'(idx_e), e.idx);
               chk("offer_cyc_e", cyc, e.cyc);
            end
         end else if (v_e && pv) begin
            chk("idx_stable_e", int'(idx_e), int'(pidx));
         end
         pv = v_e; pidx = idx_e;
      end
   end

   initial begin : mon_l
      logic       pv;
      logic [2:0] pidx;
      exp_t       e;
      pv = 1'b0; pidx = 3'd0;
      forever begin
         @(posedge clk); #1;
         if (v_l && !pv) begin
            chk("offer_expected_l", int'(q_l.size() != 0), 1);
            if (q_l.size() != 0) begin
               e = q_l.pop_front();
               chk("offer_idx_l", int'(idx_l), e.idx);
               chk("offer_cyc_l", cyc, e.cyc);
            end
         end else if (v_l && pv) begin
            chk("idx_stable_l", int'(idx_l), int'(pidx));
         end
         pv = v_l; pidx = idx_l;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int c;
      rst = 1'b1;
      irq_e = 8'hFF; mask_e = 8'hFF; rdy_e = 1'b0;
      irq_l = 8'h00; mask_l = 8'hFF; rdy_l = 1'b0;

      // Reset with requests asserted
      repeat (3) @(negedge clk);
      chk("rst_pend_raw_e", int'(pr_e), 0);
      chk("rst_pend_masked_e", int'(pm_e), 0);
      chk("rst_valid_e", int'(v_e), 0);
      chk("rst_idx_e", int'(idx_e), 0);
      chk("rst_pend_raw_l", int'(pr_l), 0);

      // Release: irq already high, first sampled at the first edge after
      c = cyc;
      exp_e(7, c + 4);
      rst = 1'b0;
      wait_until(c + 4);
      chk("offer_after_rst_e", int'(v_e), 1);

      // Asynchronous reset in the middle of the offer
      #2 rst = 1'b1;
      #1;
      chk("midrst_valid_e", int'(v_e), 0);
      chk("midrst_pend_raw_e", int'(pr_e), 0);
      chk("midrst_pend_masked_e", int'(pm_e), 0);
      chk("midrst_idx_e", int'(idx_e), 0);
      irq_e = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Single edge on irq[3], held high afterwards
      c = cyc;
      irq_e = 8'h08;
      exp_e(3, c + 4);
      wait_until(c + 2);
      chk("single_pend_early", int'(pr_e), 0);
      wait_until(c + 3);
      chk("single_pend_raw", int'(pr_e), 8'h08);
      chk("single_pend_masked", int'(pm_e), 8'h08);
      chk("single_valid_early", int'(v_e), 0);
      wait_until(c + 4);
      chk("single_valid", int'(v_e), 1);
      rdy_e = 1'b1;
      @(negedge clk);
      rdy_e = 1'b0;
      chk("single_pend_cleared", int'(pr_e), 0);
      chk("single_valid_drop", int'(v_e), 0);
      repeat (10) @(negedge clk);
      chk("single_no_reset", int'(pr_e), 0);
      irq_e = 8'h00;
      repeat (3) @(negedge clk);

      // Simultaneous edges 8'hA5, consumer always ready
      c = cyc;
      irq_e = 8'hA5; rdy_e = 1'b1;
      exp_e(7, c + 4);
      exp_e(5, c + 7);
      exp_e(2, c + 10);
      exp_e(0, c + 13);
      wait_until(c + 3);
      chk("prio_pend_all", int'(pr_e), 8'hA5);
      wait_until(c + 5);
      chk("prio_pend_after7", int'(pr_e), 8'h25);
      wait_until(c + 15);
      chk("prio_pend_empty", int'(pr_e), 0);
      chk("prio_valid_idle", int'(v_e), 0);
      rdy_e = 1'b0; irq_e = 8'h00;
      repeat (3) @(negedge clk);

      // Masked request, then unmask
      c = cyc;
      mask_e = 8'h0F; irq_e = 8'h40;
      wait_until(c + 5);
      chk("mask_pend_raw", int'(pr_e), 8'h40);
      chk("mask_pend_masked", int'(pm_e), 0);
      chk("mask_valid", int'(v_e), 0);
      mask_e = 8'hFF;
      exp_e(6, c + 7);
      wait_until(c + 6);
      chk("unmask_pend_masked", int'(pm_e), 8'h40);
      chk("unmask_valid_early", int'(v_e), 0);
      wait_until(c + 7);
      rdy_e = 1'b1;
      @(negedge clk);
      rdy_e = 1'b0; irq_e = 8'h00;
      chk("unmask_pend_cleared", int'(pr_e), 0);

      // Level mode: stall with irq[4] held, then accept while still high
      c = cyc;
      irq_l = 8'h10;
      exp_l(4, c + 4);
      wait_until(c + 4);
      for (int i = 0; i < 10; i++) begin
         chk("stall_valid_l", int'(v_l), 1);
         chk("stall_idx_l", int'(idx_l), 4);
         @(negedge clk);
      end
      c = cyc;
      rdy_l = 1'b1;
      exp_l(4, c + 3);
      @(negedge clk);
      rdy_l = 1'b0; irq_l = 8'h00;
      chk("setwins_pend_raw_l", int'(pr_l[4]), 1);
      chk("setwins_valid_l", int'(v_l), 0);
      wait_until(c + 3);
      chk("reoffer_valid_l", int'(v_l), 1);
      rdy_l = 1'b1;
      @(negedge clk);
      rdy_l = 1'b0;
      chk("level_pend_cleared_l", int'(pr_l), 0);
      repeat (10) @(negedge clk);
      chk("level_pend_quiet_l", int'(pr_l), 0);

      chk("queue_drained_e", q_e.size(), 0);
      chk("queue_drained_l", q_l.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
